des_feistel_round: RTL and testbench

- Iterative DES Feistel round engine. Holds the L/R half-block registers and drives R to the f-function each cycle.
- The f-function (expansion, key XOR, S-boxes, straight P-box) is external. This block consumes the 32-bit P-box output, XORs it into L and swaps the halves.
- Input arrives after the initial permutation. Output goes to the final permutation.
- One round per clock. round_idx selects the subkey in the key schedule.

---
 rtl/des_feistel_round.sv | 116 +++++++++++
 tb/tb_des_feistel_round.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_feistel_round.sv
// -----------------------------------------------------------------------------
// des_feistel_round
//
// Iterative DES Feistel round engine. Holds the L/R half-block registers and
// runs one round per clock against an external f-function (expansion, key
// XOR, S-boxes, straight P-box). Input arrives after the initial permutation;
// the result is the swapped pre-output R16 L16, ready for the final
// permutation.
//
// Bit ordering: vector bit 0 is DES bit 1 on every data port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only while idle. out_valid is high only
// while a finished block is held; out_block stays frozen until out_ready. A
// new block is accepted no earlier than the cycle after the output transfer.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   input block valid (ignored unless idle)
//   in_ready   out  1   engine idle, can accept a block
//   in_block   in   64  post-IP block, [31:0] = L0, [63:32] = R0
//   f_r        out  32  current R half, drives the f-function
//   f_p        in   32  f-function result, combinational from f_r/round_idx
//   round_idx  out  4   current round, 0..ROUNDS-1, selects the subkey
//   out_valid  out  1   result block valid
//   out_ready  in   1   downstream accepts the result
//   out_block  out  64  pre-output, [31:0] = R_final, [63:32] = L_final
//   dbg_state  out  2   current FSM state (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------
module des_feistel_round #(
   parameter int ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_block,
   output logic [31:0] f_r,
   input  logic [31:0] f_p,
   output logic [3:0]  round_idx,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_block,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

   state_t      r_state;
   logic [31:0] r_l;
   logic [31:0] r_r;
   logic [3:0]  r_rnd;
   logic [31:0] w_new_r;

   // f_p belongs to the f_r/round_idx presented this cycle, so the new R is
   // formed from it directly with no pipeline stage.
   assign w_new_r = r_l ^ f_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_l     <= 32'd0;
         r_r     <= 32'd0;
         r_rnd   <= 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_l     <= in_block[31:0];
                  r_r     <= in_block[63:32];
                  r_rnd   <= 4'd0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_l <= r_r;
               r_r <= w_new_r;
               // The last round leaves rnd parked at ROUNDS-1 instead of
               // wrapping, so the key schedule index stays in range.
               if (r_rnd == LAST_RND) begin
                  r_state <= DONE;
               end else begin
                  r_rnd <= r_rnd + 4'd1;
               end
            end
            DONE: begin
               // All registers freeze here until the result is taken.
               if (out_ready) begin
                  r_state <= IDLE;
                  r_rnd   <= 4'd0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign f_r       = r_r;
   assign round_idx = r_rnd;
   // The last round writes L<=R and R<=L^f, so the halves already sit in
   // swapped DES order: emitting R in the low word gives R16 L16 directly.
   assign out_block = {r_l, r_r};
   assign dbg_state = r_state;

endmodule

// File: tb/tb_des_feistel_round.sv
// -----------------------------------------------------------------------------
// tb_des_feistel_round
//
// Self-checking bench for des_feistel_round. Expected blocks are pushed into
// exp_q when a block is accepted; a monitor pops and compares on every output
// transfer. The bench supplies the f-function itself: zero, all-ones, a
// scrambling hash, or the real DES f-function with a key schedule.
// -----------------------------------------------------------------------------
module tb_des_feistel_round;

  localparam int ROUNDS = 16;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_block = 64'd0;
  logic        out_ready = 1'b0;
  logic [31:0] f_p;
  logic        in_ready;
  logic [31:0] f_r;
  logic [3:0]  round_idx;
  logic        out_valid;
  logic [63:0] out_block;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  des_feistel_round #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .f_r       (f_r),
    .f_p       (f_p),
    .round_idx (round_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- DES tables
  // Conventional DES notation: position 1 is the MSB of the value.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
                               12,13,14,15,16,17, 16,17,18,19,20,21,
                               20,21,22,23,24,25, 24,25,26,27,28,29,
                               28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                                23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SBOX_T [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  localparam int SEL_IP = 0, SEL_FP = 1, SEL_E = 2, SEL_P = 3, SEL_PC1 = 4, SEL_PC2 = 5;

  // ---------------------------------------------------------------- bench state
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  int          f_mode = 4;   // 0 zero, 1 ones, 2 hash, 3 DES, other X
  logic [47:0] ks [16];

  // ---------------------------------------------------------------- model
  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[i] = x[31-i];
    return y;
  endfunction

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[i] = x[63-i];
    return y;
  endfunction

  function automatic int tbl_len(input int sel);
    case (sel)
      SEL_IP, SEL_FP: return 64;
      SEL_E, SEL_PC2: return 48;
      SEL_P:          return 32;
      default:        return 56;
    endcase
  endfunction

  function automatic int tbl_at(input int sel, input int j);
    case (sel)
      SEL_IP:  return IP_T[j];
      SEL_FP:  return FP_T[j];
      SEL_E:   return E_T[j];
      SEL_P:   return P_T[j];
      SEL_PC1: return PC1_T[j];
      default: return PC2_T[j];
    endcase
  endfunction

  // Output position j (1 = MSB) takes input position tbl[j] (1 = MSB of in_w bits).
  function automatic logic [63:0] permute(input logic [63:0] x, input int in_w, input int sel);
    logic [63:0] y;
    int n;
    y = 64'd0;
    n = tbl_len(sel);
    for (int j = 0; j < n; j++) y[n-1-j] = x[in_w - tbl_at(sel, j)];
    return y;
  endfunction

  function automatic logic [31:0] f_des(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] e;
    logic [47:0] x;
    logic [5:0]  six;
    logic [31:0] s;
    logic [63:0] p;
    int row, col;
    e = permute({32'd0, r}, 32, SEL_E);
    x = e[47:0] ^ k;
    s = 32'd0;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      row = int'({six[5], six[0]});
      col = int'(six[4:1]);
      s[31-4*b -: 4] = 4'(SBOX_T[b*64 + row*16 + col]);
    end
    p = permute({32'd0, s}, 32, SEL_P);
    return p[31:0];
  endfunction

  function automatic logic [31:0] f_hash(input logic [31:0] r, input logic [3:0] idx);
    return (r * 32'h9E37_79B1) ^ {idx, idx, 24'h5A_5A5A} ^ {r[18:0], r[31:19]};
  endfunction

  // f_r/f_p use DUT bit order (bit 0 = DES bit 1); DES math uses MSB = bit 1.
  function automatic logic [31:0] f_model(input int mode, input logic [31:0] r, input logic [3:0] idx);
    case (mode)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return f_hash(r, idx);
      3:       return rev32(f_des(rev32(r), ks[idx]));
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Whole-block reference: ROUNDS Feistel rounds, result as {L_final, R_final}.
  function automatic logic [63:0] model(input logic [63:0] blk, input int mode);
    logic [31:0] l, r, t;
    l = blk[31:0];
    r = blk[63:32];
    for (int i = 0; i < ROUNDS; i++) begin
      t = r;
      r = l ^ f_model(mode, r, 4'(i));
      l = t;
    end
    return {l, r};
  endfunction

  always_comb f_p = f_model(f_mode, f_r, round_idx);

  // ---------------------------------------------------------------- driver tasks
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [63:0] key);
    logic [63:0] tmp;
    logic [27:0] c, d;
    f_mode = 0;
    tmp = permute(key, 64, SEL_PC1);
    c = tmp[55:28];
    d = tmp[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < SHIFT_T[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      tmp = permute({8'd0, c, d}, 56, SEL_PC2);
      ks[i] = tmp[47:0];
    end
    #1;
  endtask

  task automatic send_block(input logic [63:0] blk, input bit keep, output int unsigned acc);
    bit got;
    got = 1'b0;
    acc = 0;
    tick();
    in_block = blk;
    in_valid = 1'b1;
    for (int g = 0; g < 100 && !got; g++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        exp_q.push_back(model(blk, f_mode));
        got = 1'b1;
        #1;
        acc = cyc;
        if (!keep) in_valid = 1'b0;
      end
    end
    if (!got) begin
      in_valid = 1'b0;
      check("accept timeout", 64'd0, 64'd1);
    end
  endtask

  // Starts just after the accept edge; returns at the negedge where out_valid is seen.
  task automatic wait_done(input bit chk_idx, input bit chk_r1, input logic [31:0] r1_exp);
    int  k;
    bit  seen;
    k = 0;
    seen = 1'b0;
    while (k < 64 && !seen) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        if (chk_idx) check("round_idx", 64'(round_idx), 64'(k % 16));
        if (chk_r1 && k == 1) check("f_r after round 1", 64'(f_r), 64'(r1_exp));
        k++;
      end
    end
    if (!seen) $display("timeout waiting for out_valid, dbg_state=%0d", dbg_state);
    check("latency", 64'(k), 64'(ROUNDS));
  endtask

  // Holds the result under backpressure, then completes the output transfer.
  task automatic finish_out(input int hold, input bit chk);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (chk && exp_q.size() > 0) begin
        check("held out_block", out_block, exp_q[0]);
        check("in_ready while done", 64'(in_ready), 64'd0);
        check("out_valid held", 64'(out_valid), 64'd1);
      end
    end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    if (chk) begin
      check("in_ready after out", 64'(in_ready), 64'd1);
      check("out_valid after out", 64'(out_valid), 64'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " in_ready"},  64'(in_ready),  64'd1);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " out_block"}, out_block,      64'd0);
    check({tag, " round_idx"}, 64'(round_idx), 64'd0);
    check({tag, " f_r"},       64'(f_r),       64'd0);
  endtask

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected output", 64'd1, 64'd0);
      end else begin
        check("out_block", out_block, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [63:0] blk, c_exp, tmp;
    int unsigned acc, prev_acc;
    bit hit;

    // Reset with f_p undriven-valued: outputs must still be clean.
    rst_n = 1'b0;
    f_mode = 4;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    tick();
    rst_n = 1'b1;
    f_mode = 0;

    // f tied 0; in_valid asserted during RUN/DONE with a junk block.
    blk   = {rev32(32'h89AB_CDEF), rev32(32'h0123_4567)};
    c_exp = {rev32(32'h0123_4567), rev32(32'h89AB_CDEF)};
    send_block(blk, 1'b0, acc);
    in_block = 64'hDEAD_BEEF_0BAD_F00D;
    in_valid = 1'b1;
    wait_done(1'b1, 1'b0, 32'd0);
    in_valid = 1'b0;
    check("f zero out_block", out_block, c_exp);
    finish_out(10, 1'b1);

    // f tied all-ones: period-4 pattern returns the same halves after 16 rounds.
    f_mode = 1;
    send_block(blk, 1'b0, acc);
    wait_done(1'b1, 1'b1, rev32(32'hFEDC_BA98));
    check("f ones out_block", out_block, c_exp);
    finish_out(2, 1'b1);

    // Abort at round 7, then a clean block with full latency.
    f_mode = 2;
    send_block({$urandom, $urandom}, 1'b0, acc);
    hit = 1'b0;
    for (int g = 0; g < 40 && !hit; g++) begin
      @(negedge clk);
      if (round_idx == 4'd7) hit = 1'b1;
    end
    check("reached round 7", 64'(hit), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("abort");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    send_block({$urandom, $urandom}, 1'b0, acc);
    wait_done(1'b1, 1'b0, 32'd0);
    finish_out(0, 1'b1);

    // Full DES with IP, f-function, FP and key schedule: known-answer test.
    load_key(64'h1334_5779_9BBC_DFF1);
    f_mode = 3;
    tmp = permute(64'h0123_4567_89AB_CDEF, 64, SEL_IP);
    send_block(rev64(tmp), 1'b0, acc);
    wait_done(1'b0, 1'b0, 32'd0);
    check("DES ciphertext", permute(rev64(out_block), 64, SEL_FP), 64'h85E8_1354_0F0A_B405);
    finish_out(0, 1'b0);

    // Back-to-back with out_ready tied high: accepts ROUNDS+2 cycles apart.
    f_mode = 2;
    out_ready = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      send_block({$urandom, $urandom}, 1'b1, acc);
      if (i > 0) check("accept gap", 64'(acc - prev_acc), 64'(ROUNDS + 2));
      prev_acc = acc;
    end
    in_valid = 1'b0;
    repeat (ROUNDS + 4) tick();
    out_ready = 1'b0;

    // Randomised blocks, f-functions, keys, idle gaps and backpressure.
    for (int i = 0; i < 24; i++) begin
      int m;
      m = int'($urandom_range(0, 3));
      if (m == 3) load_key({$urandom, $urandom});
      f_mode = m;
      repeat ($urandom_range(0, 3)) tick();
      send_block({$urandom, $urandom}, 1'b0, acc);
      wait_done(1'b1, 1'b0, 32'd0);
      finish_out(int'($urandom_range(0, 4)), 1'b1);
    end

    repeat (3) tick();
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
